// File: rtl/imap_bank_buf.sv
// imap_bank_buf: banked input-feature-map buffer, BIU write side / MAC-array lane-gather read side.
// Define IMAP_ZPAD_EN to add rd_pad_mask (zero-padded lanes skip the SRAM).
module sram_32kb_4kx64 (
  input  logic        clk,
  input  logic        i_cs,
  input  logic        i_we,
  input  logic [11:0] i_addr,
  input  logic [63:0] i_din,
  input  logic [7:0]  i_be,
  output logic [63:0] o_dout
);
  logic [63:0] r_mem [4096];
  logic [63:0] r_dout;
  always_ff @(posedge clk)
    if (i_cs) begin
      if (i_we) begin
        for (int k = 0; k < 8; k++) if (i_be[k]) r_mem[i_addr][8*k +: 8] <= i_din[8*k +: 8];
      end else r_dout <= r_mem[i_addr];
    end
  assign o_dout = r_dout;
endmodule

module imap_bank_buf #(
  parameter int DATA_W      = 64,
  parameter int BANK_DEPTH  = 4096,
  parameter int NUM_BANKS   = 7,
  parameter int RD_LANES    = 4,
  parameter int BLOCK_SIZE  = 3136,
  parameter int LANE_STRIDE = 2,
  parameter int BLK_W       = 1,
  parameter int AW          = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_wr_valid,
  output logic                         o_wr_ready,
  input  logic [AW-1:0]                i_wr_addr,
  input  logic [DATA_W-1:0]            i_wr_data,
  input  logic [DATA_W/8-1:0]          i_wr_mask,
  input  logic                         i_rd_req,
  output logic                         o_rd_ready,
  input  logic [BLK_W-1:0]             i_rd_blk,
  input  logic [$clog2(BLOCK_SIZE)-1:0] i_rd_off,
`ifdef IMAP_ZPAD_EN
  input  logic [RD_LANES-1:0]          i_rd_pad_mask,
`endif
  output logic                         o_rd_valid,
  output logic [RD_LANES*DATA_W-1:0]   o_rd_data,
  output logic [$clog2(RD_LANES):0]    o_rd_rounds,
  output logic                         o_err_oob
);
  localparam int RW  = $clog2(BANK_DEPTH);
  localparam int BW  = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  localparam int CW  = $clog2(RD_LANES) + 1;
  localparam int LW  = 32;
  localparam int TOT = NUM_BANKS * BANK_DEPTH;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_t;
  state_t r_state, w_next;
  logic [BW-1:0] r_bank [RD_LANES];
  logic [RW-1:0] r_row [RD_LANES];
  logic [RD_LANES-1:0] r_pend, r_gnt, w_gnt, w_lo, w_pad;
  logic [RD_LANES*DATA_W-1:0] r_buf, w_buf, r_data;
  logic [CW-1:0] r_rounds, r_rd_rounds;
  logic r_valid, r_err, w_wbusy, w_woob, w_wr;
  logic [LW-1:0] w_la [RD_LANES];
  logic [NUM_BANKS-1:0] w_bsel;
  logic [RW-1:0] w_brow [NUM_BANKS];
  logic [DATA_W-1:0] w_dout_a [NUM_BANKS];
  logic [AW-RW-1:0] w_wbank;
`ifdef IMAP_ZPAD_EN
  assign w_pad = i_rd_pad_mask;
`else
  assign w_pad = '0;
`endif
  always_comb
    for (int j = 0; j < RD_LANES; j++) begin
      w_la[j] = (LW'(LANE_STRIDE * j) + LW'(i_rd_blk)) * LW'(BLOCK_SIZE) + LW'(i_rd_off);
      w_lo[j] = w_la[j] >= LW'(TOT);
    end
  // Walking lanes in index order lets the lowest pending lane claim each bank first.
  always_comb begin
    w_gnt  = '0;
    w_bsel = '0;
    for (int b = 0; b < NUM_BANKS; b++) w_brow[b] = '0;
    if (r_state == ISSUE)
      for (int j = 0; j < RD_LANES; j++)
        if (r_pend[j] && !w_bsel[r_bank[j]]) begin
          w_gnt[j]          = 1'b1;
          w_bsel[r_bank[j]] = 1'b1;
          w_brow[r_bank[j]] = r_row[j];
        end
  end
  assign w_wbank = i_wr_addr[AW-1:RW];
  assign w_woob  = i_wr_addr >= AW'(TOT);
  always_comb begin
    w_wbusy = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) if (w_bsel[b] && w_wbank == (AW-RW)'(b)) w_wbusy = 1'b1;
  end
  assign o_wr_ready = !w_wbusy;
  assign w_wr       = i_wr_valid && o_wr_ready && !w_woob;
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic w_cs, w_we;
    logic [RW-1:0] w_addr;
    assign w_we   = w_wr && w_wbank == (AW-RW)'(b);
    assign w_cs   = w_bsel[b] || w_we;
    assign w_addr = w_bsel[b] ? w_brow[b] : i_wr_addr[RW-1:0];
    if (DATA_W == 64 && BANK_DEPTH == 4096) begin : g_mac
      sram_32kb_4kx64 u_sram (.clk(clk), .i_cs(w_cs), .i_we(w_we), .i_addr(w_addr),
                              .i_din(i_wr_data), .i_be(i_wr_mask), .o_dout(w_dout_a[b]));
    end else begin : g_inf
      logic [DATA_W-1:0] r_mem [BANK_DEPTH];
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk)
        if (w_cs) begin
          if (w_we) begin
            for (int k = 0; k < DATA_W/8; k++) if (i_wr_mask[k]) r_mem[w_addr][8*k +: 8] <= i_wr_data[8*k +: 8];
          end else r_q <= r_mem[w_addr];
        end
      assign w_dout_a[b] = r_q;
    end
  end
  always_comb begin
    w_buf = r_buf;
    for (int j = 0; j < RD_LANES; j++) if (r_gnt[j]) w_buf[j*DATA_W +: DATA_W] = w_dout_a[r_bank[j]];
  end
  always_comb
    w_next = r_state == IDLE  ? (i_rd_req ? ISSUE : IDLE) :
             r_state == ISSUE ? CAPT :
             r_state == CAPT  ? ((r_pend & ~r_gnt) != '0 ? ISSUE : DONE) : IDLE;
  always_ff @(posedge clk)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // Out-of-range and padded lanes never enter the pending set, so their slots stay zero.
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_pend      <= '0;
      r_gnt       <= '0;
      r_buf       <= '0;
      r_rounds    <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_rd_rounds <= '0;
      r_err       <= 1'b0;
    end else begin
      r_valid <= r_state == CAPT && w_next == DONE;
      if (i_wr_valid && o_wr_ready && w_woob) r_err <= 1'b1;
      if (r_state == IDLE && i_rd_req) begin
        for (int j = 0; j < RD_LANES; j++) begin
          r_bank[j] <= w_la[j][RW +: BW];
          r_row[j]  <= w_la[j][RW-1:0];
          r_pend[j] <= !w_lo[j] && !w_pad[j];
        end
        r_buf    <= '0;
        r_rounds <= '0;
        if ((w_lo & ~w_pad) != '0) r_err <= 1'b1;
      end
      if (r_state == ISSUE) begin
        r_gnt    <= w_gnt;
        r_rounds <= r_rounds + CW'(1);
      end
      if (r_state == CAPT) begin
        r_buf  <= w_buf;
        r_pend <= r_pend & ~r_gnt;
        if (w_next == DONE) begin
          r_data      <= w_buf;
          r_rd_rounds <= r_rounds;
        end
      end
    end
  assign o_rd_ready  = r_state == IDLE;
  assign o_rd_valid  = r_valid;
  assign o_rd_data   = r_data;
  assign o_rd_rounds = r_rd_rounds;
  assign o_err_oob   = r_err;
endmodule

// File: tb/tb_imap_bank_buf.sv
// tb_imap_bank_buf: scoreboard bench over three parameterisations (default, LANE_STRIDE=1, NUM_BANKS=6).
module tb_imap_bank_buf;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic        wr_valid [3], wr_ready [3], rd_req [3], rd_ready [3], rd_valid [3], err_oob [3];
  logic [31:0] wr_addr [3];
  logic [63:0] wr_data [3];
  logic [7:0]  wr_mask [3];
  logic        rd_blk [3];
  logic [11:0] rd_off [3];
  logic [3:0]  pad [3];
  logic [255:0] rd_data [3];
  logic [2:0]  rd_rounds [3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    imap_bank_buf #(.LANE_STRIDE(g == 1 ? 1 : 2), .NUM_BANKS(g == 2 ? 6 : 7)) u (
      .clk(clk), .rst_n(rst_n),
      .i_wr_valid(wr_valid[g]), .o_wr_ready(wr_ready[g]), .i_wr_addr(wr_addr[g]),
      .i_wr_data(wr_data[g]), .i_wr_mask(wr_mask[g]),
      .i_rd_req(rd_req[g]), .o_rd_ready(rd_ready[g]), .i_rd_blk(rd_blk[g]), .i_rd_off(rd_off[g]),
`ifdef IMAP_ZPAD_EN
      .i_rd_pad_mask(pad[g]),
`endif
      .o_rd_valid(rd_valid[g]), .o_rd_data(rd_data[g]), .o_rd_rounds(rd_rounds[g]),
      .o_err_oob(err_oob[g]));
  end
  typedef struct {int inst; logic [255:0] data; logic [2:0] rounds; int due;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  always @(negedge clk)
    for (int i = 0; i < 3; i++)
      if (rd_valid[i]) begin
        exp_t e;
        if (q.size() == 0) chk("unexpected rd_valid", rd_valid[i], 0);
        else begin
          e = q.pop_front();
          chk("rd instance", i, e.inst);
          chk("rd_data", rd_data[i], e.data);
          chk("rd_rounds", rd_rounds[i], e.rounds);
          chk("rd latency", cyc, e.due);
        end
      end
  task automatic wr(int i, logic [31:0] a, logic [63:0] d, logic [7:0] m);
    @(negedge clk);
    wr_valid[i] = 1'b1; wr_addr[i] = a; wr_data[i] = d; wr_mask[i] = m;
    #1;
    for (int t = 0; t < 20 && !wr_ready[i]; t++) begin @(negedge clk); #1; end
    @(negedge clk);
    wr_valid[i] = 1'b0;
  endtask
  task automatic rd(int i, logic b, logic [11:0] o, logic [3:0] p, logic [255:0] ed, logic [2:0] er, int k);
    @(negedge clk);
    rd_req[i] = 1'b1; rd_blk[i] = b; rd_off[i] = o; pad[i] = p;
    for (int t = 0; t < 20 && !rd_ready[i]; t++) @(negedge clk);
    q.push_back(exp_t'{i, ed, er, cyc + 1 + 2 * k});
    @(negedge clk);
    rd_req[i] = 1'b0;
  endtask
  task automatic wait_done();
    for (int t = 0; t < 40 && q.size() != 0; t++) @(negedge clk);
    if (q.size() != 0) begin
      chk("read timeout", q.size(), 0);
      q.delete();
    end
  endtask
  logic [63:0] a0 = 64'h1111_2222_3333_0000, a1 = 64'h1111_2222_3333_0001;
  logic [63:0] a2 = 64'h1111_2222_3333_0002, a3 = 64'h1111_2222_3333_0003;
  logic [63:0] c1 = 64'hC1C1_C1C1_C1C1_C1C1, a2m;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 3; i++) begin
      wr_valid[i] = 0; wr_addr[i] = 0; wr_data[i] = 0; wr_mask[i] = 0;
      rd_req[i] = 0; rd_blk[i] = 0; rd_off[i] = 0; pad[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset rd_valid", rd_valid[0], 0);
    chk("reset rd_data", rd_data[0], 0);
    chk("reset rd_rounds", rd_rounds[0], 0);
    chk("reset err_oob", err_oob[0], 0);
    chk("reset rd_ready", rd_ready[0], 1);
    rst_n = 1'b1;
    wr(0, 0, a0, 8'hFF); wr(0, 6272, a1, 8'hFF); wr(0, 12544, a2, 8'hFF); wr(0, 18816, a3, 8'hFF);
    rd(0, 0, 0, 4'h0, {a3, a2, a1, a0}, 1, 1);
    wait_done();
    wr(1, 0, 64'hB0, 8'hFF); wr(1, 3136, 64'hB1, 8'hFF); wr(1, 6272, 64'hB2, 8'hFF); wr(1, 9408, 64'hB3, 8'hFF);
    rd(1, 0, 0, 4'h0, {64'hB3, 64'hB2, 64'hB1, 64'hB0}, 2, 2);
    wait_done();
    rd(0, 0, 0, 4'h0, {a3, a2, a1, a0}, 1, 1);
    wr_valid[0] = 1'b1; wr_addr[0] = 8192; wr_data[0] = c1; wr_mask[0] = 8'hFF;
    #1 chk("wr_ready free bank in ISSUE", wr_ready[0], 1);
    wr_addr[0] = 6272;
    #1 chk("wr_ready granted bank in ISSUE", wr_ready[0], 0);
    @(negedge clk);
    #1 chk("wr_ready after ISSUE", wr_ready[0], 1);
    @(negedge clk);
    wr_valid[0] = 1'b0;
    wait_done();
    rd(0, 0, 0, 4'h0, {a3, a2, c1, a0}, 1, 1);
    wait_done();
    wr(0, 12544, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    a2m = {a2[63:32], 32'hFFFF_FFFF};
    rd(0, 0, 0, 4'h0, {a3, a2m, c1, a0}, 1, 1);
    wait_done();
    chk("err_oob before oob write", err_oob[0], 0);
    @(negedge clk);
    wr_valid[0] = 1'b1; wr_addr[0] = 28672; wr_data[0] = 64'hDEAD; wr_mask[0] = 8'hFF;
    #1 chk("wr_ready oob write", wr_ready[0], 1);
    @(negedge clk);
    wr_valid[0] = 1'b0;
    chk("err_oob after oob write", err_oob[0], 1);
    rd(0, 0, 0, 4'h0, {a3, a2m, c1, a0}, 1, 1);
    wait_done();
    wr(2, 6136, 64'hE1, 8'hFF); wr(2, 12408, 64'hE2, 8'hFF); wr(2, 18680, 64'hE3, 8'hFF);
    chk("err_oob u2 before read", err_oob[2], 0);
    rd(2, 1, 3000, 4'h0, {64'h0, 64'hE3, 64'hE2, 64'hE1}, 1, 1);
    wait_done();
    chk("err_oob u2 after oob lane", err_oob[2], 1);
`ifdef IMAP_ZPAD_EN
    rd(0, 0, 0, 4'b0101, {a3, 64'h0, c1, 64'h0}, 1, 1);
    wait_done();
    rd(0, 0, 0, 4'b1111, 256'h0, 1, 1);
    wait_done();
`endif
    rd(0, 0, 0, 4'h0, {a3, a2m, c1, a0}, 1, 1);
    @(negedge clk);
    rst_n = 1'b0;
    void'(q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid-read reset rd_valid", rd_valid[0], 0);
    chk("mid-read reset rd_data", rd_data[0], 0);
    chk("mid-read reset rd_ready", rd_ready[0], 1);
    chk("mid-read reset err_oob u0", err_oob[0], 0);
    chk("mid-read reset err_oob u2", err_oob[2], 0);
    repeat (10) @(negedge clk);
    chk("scoreboard empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
